// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   DefNReq / DefMulLat : default requester count and multiplier latency.
//   MaxNReq / TagW      : largest supported requester count and the tag field width it needs.
//   tag_entry_t         : one tag-pipe stage (valid bit plus requester tag).
//   tag_width()         : clog2(n), clamped to at least one bit, for grant-index buses.
// Optional feature macro used by the block: MUL_SHARE_PRIO_EN.
package mul_share_pkg;

  localparam int unsigned DefNReq   = 4;
  localparam int unsigned DefMulLat = 4;
  localparam int unsigned MaxNReq   = 8;
  localparam int unsigned TagW      = $clog2(MaxNReq);

  typedef struct packed {
    logic            valid;
    logic [TagW-1:0] tag;
  } tag_entry_t;

  function automatic int unsigned tag_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks one request per cycle, searching upward from the index after
// the last granted one and wrapping around.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset; makes index 0 the highest priority
//   req_i     : request vector
//   en_i      : allow the pointer to advance when a grant is made
//   gnt_o     : one-hot grant (combinational)
//   gnt_idx_o : binary index of the grant (valid when gnt_o is non-zero)
module rr_arbiter #(
  parameter int unsigned NReq = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NReq-1:0] req_i,
  input  logic            en_i,
  output logic [NReq-1:0] gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [NReq-1:0] req_hi;
  logic [IdxW-1:0] sel_hi, sel_lo;
  logic            any_hi, any_lo;

  always_comb begin
    // Requests strictly above the last grant win first; otherwise wrap to the lowest one.
    req_hi = '0;
    for (int i = 0; i < int'(NReq); i++) begin
      req_hi[i] = req_i[i] && (i > int'(ptr_q));
    end
    sel_hi = '0;
    sel_lo = '0;
    any_hi = 1'b0;
    any_lo = 1'b0;
    for (int i = int'(NReq) - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        any_hi = 1'b1;
        sel_hi = IdxW'(i);
      end
      if (req_i[i]) begin
        any_lo = 1'b1;
        sel_lo = IdxW'(i);
      end
    end
    gnt_idx_o = any_hi ? sel_hi : sel_lo;
    gnt_o     = '0;
    if (any_lo) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
    ptr_d = (en_i && any_lo) ? gnt_idx_o : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= IdxW'(NReq - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one external pipelined 32x32 multiplier among NREQ requesters.
// One requester is granted per cycle; its operands are registered onto mul_a/mul_b and a
// valid+tag entry travels down a tag pipe aligned with the multiplier so the product can be
// routed back as a one-cycle rsp_valid pulse, MUL_LAT+1 cycles after the accepting edge.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (ready only on the granted index)
//   req_a, req_b         : packed 32-bit operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_result : per-requester response pulse and 64-bit product
//   mul_a, mul_b         : operands to the shared multiplier
//   mul_result           : product from the shared multiplier, MUL_LAT cycles after mul_a/mul_b
// Macro MUL_SHARE_PRIO_EN: requester 0 gets fixed priority, round-robin among the rest.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned NREQ    = DefNReq,
  parameter int unsigned MUL_LAT = DefMulLat
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [63:0]          rsp_result,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_result
);

  localparam int unsigned ArbW = tag_width(NREQ);

  logic [NREQ-1:0] arb_req, arb_gnt, grant, grant_m;
  logic [ArbW-1:0] arb_idx, grant_idx;
  logic            arb_en, any_grant;
  logic [31:0]     sel_a, sel_b;
  logic [31:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  tag_entry_t      iss_q, iss_d;
  tag_entry_t      pipe_q [MUL_LAT];
  tag_entry_t      pipe_d [MUL_LAT];
  tag_entry_t      tail;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [63:0]     rsp_result_q, rsp_result_d;

  rr_arbiter #(
    .NReq (NREQ),
    .IdxW (ArbW)
  ) u_rr_arbiter (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (arb_req),
    .en_i      (arb_en),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
`ifdef MUL_SHARE_PRIO_EN
    // Requester 0 bypasses the arbiter; the round-robin pointer only moves on others.
    arb_req   = {req_valid[NREQ-1:1], 1'b0};
    grant     = req_valid[0] ? NREQ'(1) : arb_gnt;
    grant_idx = req_valid[0] ? '0 : arb_idx;
    arb_en    = !req_valid[0];
`else
    arb_req   = req_valid;
    grant     = arb_gnt;
    grant_idx = arb_idx;
    arb_en    = 1'b1;
`endif
    grant_m   = rst ? '0 : grant;
    any_grant = |grant_m;
  end

  assign req_ready = grant_m;

  // Operand mux and issue stage.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_m[i]) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
    mul_a_d   = any_grant ? sel_a : mul_a_q;
    mul_b_d   = any_grant ? sel_b : mul_b_q;
    iss_d.valid = any_grant;
    iss_d.tag   = TagW'(grant_idx);
  end

  // Tag pipe: iss_q rides alongside mul_a/mul_b, pipe_q tracks the multiplier's stages so the
  // tail is valid in the same cycle its product sits on mul_result.
  always_comb begin
    pipe_d[0] = iss_q;
    for (int k = 1; k < int'(MUL_LAT); k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
    tail = pipe_q[MUL_LAT-1];
    for (int i = 0; i < int'(NREQ); i++) begin
      rsp_valid_d[i] = tail.valid && (tail.tag == TagW'(i));
    end
    rsp_result_d = tail.valid ? mul_result : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      iss_q        <= '0;
      for (int k = 0; k < int'(MUL_LAT); k++) begin
        pipe_q[k] <= '0;
      end
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
    end else begin
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      iss_q        <= iss_d;
      pipe_q       <= pipe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  // Gated so the outputs read zero for the whole reset cycle, not just after its edge.
  assign rsp_valid  = rst ? '0 : rsp_valid_q;
  assign rsp_result = rst ? '0 : rsp_result_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter with a MUL_LAT-deep behavioural multiplier.
// Reference model: round-robin pick over requester indices plus a queue of expected
// responses (requester, product, due cycle).
`timescale 1ns/1ps
module tb_mul_share_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a, req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [63:0]         rsp_result;
  logic [31:0]         mul_a, mul_b;
  logic [63:0]         mul_result;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result)
  );

  // Behavioural shared multiplier.
  logic [63:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  typedef struct {
    int          due;
    int          req;
    logic [63:0] prod;
  } exp_t;

  exp_t            exp_q[$];
  int              n_cmp = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              last = NREQ - 1;
  int              resp_cnt [NREQ];
  int              dut_ret = 0;
  int              n_acc = 0;
  logic [NREQ-1:0] obs_rv, obs_ready;
  logic [63:0]     obs_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next grant from the arbitration rules: scan upward from last+1 with wraparound.
  function automatic int pick(input logic [NREQ-1:0] v, input int lst);
`ifdef MUL_SHARE_PRIO_EN
    if (v[0]) return 0;
    for (int s = 1; s <= NREQ; s++) begin
      int i;
      i = (lst + s) % NREQ;
      if (i != 0 && v[i]) return i;
    end
`else
    for (int s = 1; s <= NREQ; s++) begin
      int i;
      i = (lst + s) % NREQ;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [32*NREQ-1:0] rand_ops();
    logic [32*NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [32*NREQ-1:0] fill_ops(input logic [31:0] base, input bit inc);
    logic [32*NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) r[32*i +: 32] = inc ? base + 32'(i) : base;
    return r;
  endfunction

  // One clock of normal operation; entered and left at the falling edge.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [32*NREQ-1:0] a,
                       input logic [32*NREQ-1:0] b);
    int              g;
    logic [NREQ-1:0] er, ev;
    logic [63:0]     eres;
    exp_t            e;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    g  = pick(v, last);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    if (g >= 0) begin
      e.due  = cyc + MUL_LAT + 2;
      e.req  = g;
      e.prod = {32'b0, a[32*g +: 32]} * {32'b0, b[32*g +: 32]};
      exp_q.push_back(e);
      n_acc++;
`ifdef MUL_SHARE_PRIO_EN
      if (g != 0) last = g;
`else
      last = g;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    ev   = '0;
    eres = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev[exp_q[0].req] = 1'b1;
      eres = exp_q[0].prod;
      void'(exp_q.pop_front());
    end
    obs_rv = rsp_valid;
    obs_rr = rsp_result;
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev != 0) chk("rsp_result", rsp_result, eres);
    if (rsp_valid != 0) dut_ret++;
    for (int i = 0; i < NREQ; i++) if (rsp_valid[i] === 1'b1) resp_cnt[i]++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      req_valid = NREQ'($urandom);
      req_a     = rand_ops();
      req_b     = rand_ops();
      #1;
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_result", rsp_result, 64'(0));
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_rsp_valid_edge", 64'(rsp_valid), 64'(0));
      @(negedge clk);
    end
    rst       = 1'b0;
    req_valid = '0;
    exp_q.delete();
    last = NREQ - 1;
    chk("rst_mul_a", 64'(mul_a), 64'(0));
    chk("rst_mul_b", 64'(mul_b), 64'(0));
  endtask

  task automatic drain();
    for (int k = 0; k < MUL_LAT + 3; k++) cycle('0, '0, '0);
  endtask

  initial begin
    int c0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) resp_cnt[i] = 0;
    @(negedge clk);
    do_reset(2);

    // Single request: 7*6 after MUL_LAT+1 cycles.
    c0 = cyc;
    cycle(4'b0001, fill_ops(32'd7, 1'b0), fill_ops(32'd6, 1'b0));
    for (int k = 0; k < MUL_LAT + 3; k++) begin
      cycle('0, '0, '0);
      if (cyc == c0 + MUL_LAT + 2) begin
        chk("t032_valid", 64'(obs_rv), 64'(4'b0001));
        chk("t032_result", obs_rr, 64'd42);
      end
    end

    // All four valid for 8 cycles.
    do_reset(1);
    for (int i = 0; i < NREQ; i++) resp_cnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(4'hF, fill_ops(32'd1, 1'b1), fill_ops(32'h10000, 1'b0));
`ifndef MUL_SHARE_PRIO_EN
      chk("t033_order", 64'(obs_ready), 64'(4'b0001 << (k % 4)));
`endif
    end
    drain();
`ifndef MUL_SHARE_PRIO_EN
    for (int i = 0; i < NREQ; i++) chk("t033_count", 64'(resp_cnt[i]), 64'd2);
`endif

    // Requester 2 streaming full-scale operands.
    for (int i = 0; i < NREQ; i++) resp_cnt[i] = 0;
    for (int k = 0; k < 6 + MUL_LAT + 3; k++) begin
      if (k < 6) begin
        cycle(4'b0100, fill_ops(32'hFFFF_FFFF, 1'b0), fill_ops(32'hFFFF_FFFF, 1'b0));
        chk("t034_ready", 64'(obs_ready), 64'(4'b0100));
      end else begin
        cycle('0, '0, '0);
      end
      if (obs_rv != 0) begin
        chk("t034_rv", 64'(obs_rv), 64'(4'b0100));
        chk("t034_result", obs_rr, 64'hFFFF_FFFE_0000_0001);
      end
    end
    chk("t034_count", 64'(resp_cnt[2]), 64'd6);

    // Reset with three operations in flight.
    cycle(4'b0010, rand_ops(), rand_ops());
    cycle(4'b0100, rand_ops(), rand_ops());
    cycle(4'b1000, rand_ops(), rand_ops());
    do_reset(1);
    for (int k = 0; k < MUL_LAT + 1; k++) begin
      cycle('0, '0, '0);
      chk("t035_quiet", 64'(obs_rv), 64'(0));
    end
    cycle(4'hF, rand_ops(), rand_ops());
    chk("t035_next", 64'(obs_ready), 64'(4'b0001));
    drain();

`ifdef MUL_SHARE_PRIO_EN
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      cycle(4'b0011, rand_ops(), rand_ops());
      chk("t036_prio", 64'(obs_ready), 64'(4'b0001));
    end
    drain();
`endif

    // Random traffic.
    dut_ret = 0;
    n_acc   = 0;
    for (int k = 0; k < 1000; k++) cycle(NREQ'($urandom), rand_ops(), rand_ops());
    drain();
    chk("t037_returned", 64'(dut_ret), 64'(n_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MUL_LAT, default 4, fixed multiplier latency in cycles, input to result (1..16).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester operand-valid.
REQ-006 SHALL have port req_ready, output, NREQ, per-requester accept; a transfer occurs when valid and ready are both high.
REQ-007 SHALL have port req_a, input, 32*NREQ, operand A for requester i at bits [32i+31:32i].
REQ-008 SHALL have port req_b, input, 32*NREQ, operand B, same packing.
REQ-009 SHALL have port rsp_valid, output, NREQ, one-cycle pulse marking the requester's product.
REQ-010 SHALL have port rsp_result, output, 64, product, meaningful only while any rsp_valid bit is high.
REQ-011 SHALL have ports mul_a and mul_b, output, 32 each, operands to the shared vedic32x32.
REQ-012 SHALL have port mul_result, input, 64, multiplier product.

Function
REQ-013 SHALL grant at most one requester per cycle, with round-robin priority starting after the last granted index.
REQ-014 SHALL assert req_ready only on the granted index, combinationally from req_valid and the round-robin pointer.
REQ-015 SHALL register the granted operands onto mul_a/mul_b on the grant edge, holding the last issued values when idle.
REQ-016 SHALL carry a valid bit plus requester tag through a MUL_LAT-deep shift register aligned with the multiplier.
REQ-017 SHALL, when the tag pipe's tail is valid, pulse rsp_valid[tag] for exactly one cycle and present mul_result on rsp_result that cycle.
REQ-018 SHALL give a total latency of MUL_LAT+1 cycles from the accepting edge to rsp_valid.
REQ-019 SHALL sustain one issue per cycle (full pipelining) with no response backpressure.
REQ-020 SHALL advance the round-robin pointer only on a grant; an idle cycle leaves it unchanged.
REQ-021 SHALL, with a single active requester, grant it every cycle.
REQ-022 SHALL return responses in issue order, including several outstanding for one requester.
REQ-023 SHALL compute 32x32 unsigned products to a 64-bit result with no truncation (0xFFFFFFFF squared = 0xFFFFFFFE00000001).

Reset
REQ-024 SHALL, on rst, clear the tag pipe valid bits, set the pointer so requester 0 has highest priority, and zero mul_a/mul_b.
REQ-025 SHALL hold req_ready, rsp_valid and rsp_result at 0 while rst is high.
REQ-026 SHALL drop every in-flight operation on a mid-operation reset, producing no rsp_valid for it afterwards.

Configuration
REQ-027 SHALL, with MUL_SHARE_PRIO_EN defined, give requester 0 fixed priority over all others and round-robin only among requesters 1..NREQ-1.
REQ-028 SHALL, without MUL_SHARE_PRIO_EN, use pure round-robin over all NREQ requesters.

Structure
REQ-029 SHALL place the default NREQ, default MUL_LAT, the tag width clog2(NREQ), and the tag-pipe entry typedef (valid plus tag) in package mul_share_pkg.
REQ-030 SHALL implement the grant logic as sub-module rr_arbiter (request vector in, one-hot grant out, pointer update on enable).
REQ-031 SHALL leave vedic32x32 outside the block; the bench instantiates it, or a MUL_LAT-deep behavioural model, alongside the block.

Verification
REQ-032 SHALL cover: reset, then req_valid=0001 with a=7, b=6 -> rsp_valid=0001 and rsp_result=42 exactly MUL_LAT+1 cycles later.
REQ-033 SHALL cover: all four requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and each gets two correct products (a=i+1, b=0x10000).
REQ-034 SHALL cover: requester 2 streaming back-to-back with a=0xFFFFFFFF, b=0xFFFFFFFF -> consecutive rsp_valid=0100, each with result 0xFFFFFFFE00000001.
REQ-035 SHALL cover: rst pulsed for 1 cycle with 3 operations in flight -> no rsp_valid in the following MUL_LAT+1 cycles, and the next grant goes to requester 0.
REQ-036 SHALL cover: with MUL_SHARE_PRIO_EN and requesters 0 and 1 both valid continuously -> requester 0 granted every cycle and requester 1 never.
REQ-037 SHALL cover: 1000 random cycles with random req_valid -> every accepted a*b returned once, to its own requester, in order.
